// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus: frame geometry, mode-bit encoding, master FSM states.
// Latency: none (package only).
// Backpressure: none (package only).
package bus_pkg;

    localparam int ADDR_WIDTH      = 14;
    localparam int DATA_WIDTH      = 8;
    localparam int READ_FRAME_LEN  = 1 + ADDR_WIDTH;
    localparam int WRITE_FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;

    // First bit of every frame tells the slave which way the transfer goes
    localparam logic MODE_READ  = 1'b1;
    localparam logic MODE_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND,
        ST_WAIT_ACK,
        ST_RECV,
        ST_DONE,
        ST_ERR
    } state_t;

    // Number of serial bits in a frame; reads carry no data field
    function automatic int frame_len(input int aw, input int dw, input logic rd);
        return rd ? (1 + aw) : (1 + aw + dw);
    endfunction

endpackage

// File: rtl/frame_shifter.sv
// Parallel-load, MSB-first shift register holding the outgoing serial frame.
// Latency: loaded word's MSB visible the cycle after load; each shift exposes the next bit one cycle later.
// Backpressure: none; shifts only when the owner asserts i_shift.
module frame_shifter #(
    parameter int WIDTH = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_shift;

    // Load wins over shift; zeros fill from the bottom so a drained frame reads as 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_shift[WIDTH-1];

endmodule

// File: rtl/master_port.sv
// Master-side serial bus port: takes one read/write command, arbitrates, sends the frame, returns data or error.
// Latency: enable -> bus_req next cycle; frame 15/23 cycles after grant; done one cycle after ack (write) or 8th rx bit (read).
// Backpressure: commands accepted only in IDLE (busy low); enable at any other time is dropped, not queued.
module master_port #(
    parameter int ADDR_WIDTH = bus_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = bus_pkg::DATA_WIDTH,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  bus_req,
    input  logic                  bus_grant,
    output logic                  tx_bit,
    output logic                  tx_valid,
    input  logic                  slave_ack,
    input  logic                  rx_bit,
    input  logic                  rx_valid
);

    import bus_pkg::*;

    localparam int FRAME_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int BCW     = $clog2(FRAME_W);
    localparam int TCW     = $clog2(TIMEOUT + 1);
    localparam int RCW     = $clog2(DATA_WIDTH);

    localparam logic [BCW-1:0] RD_LAST = BCW'(frame_len(ADDR_WIDTH, DATA_WIDTH, 1'b1) - 1);
    localparam logic [BCW-1:0] WR_LAST = BCW'(frame_len(ADDR_WIDTH, DATA_WIDTH, 1'b0) - 1);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);
    localparam logic [RCW-1:0] RX_LAST = RCW'(DATA_WIDTH - 1);

    state_t                r_state;
    logic                  r_read;
    logic [BCW-1:0]        r_bit_cnt;
    logic [TCW-1:0]        r_to_cnt;
    logic [RCW-1:0]        r_rx_cnt;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  r_bus_req;
    logic                  r_tx_valid;

    logic                  w_load;
    logic                  w_shift;
    logic                  w_frame_msb;
    logic [DATA_WIDTH-1:0] w_frame_data;
    logic [FRAME_W-1:0]    w_frame;
    logic [BCW-1:0]        w_frame_last;

    // The frame is captured into the shifter at accept time, so no separate command register is needed
    assign w_load       = (r_state == ST_IDLE) && enable;
    assign w_shift      = (r_state == ST_SEND) && bus_grant;
    assign w_frame_data = read_en ? '0 : data_in;
    assign w_frame      = {(read_en ? MODE_READ : MODE_WRITE), addr_in, w_frame_data};
    assign w_frame_last = r_read ? RD_LAST : WR_LAST;

    frame_shifter #(
        .WIDTH (FRAME_W)
    ) u_frame_shifter (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (w_frame),
        .o_msb   (w_frame_msb)
    );

    // Transaction FSM with registered status/handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_read     <= 1'b0;
            r_bit_cnt  <= '0;
            r_to_cnt   <= '0;
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_bus_req  <= 1'b0;
            r_tx_valid <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_read    <= read_en;
                        r_busy    <= 1'b1;
                        r_bus_req <= 1'b1;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Arbitration may take arbitrarily long; no timeout here
                    if (bus_grant) begin
                        r_bit_cnt  <= '0;
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Grant is rechecked on every bit, including the last one
                    if (!bus_grant) begin
                        r_tx_valid <= 1'b0;
                        r_error    <= 1'b1;
                        r_state    <= ST_ERR;
                    end else if (r_bit_cnt == w_frame_last) begin
                        r_tx_valid <= 1'b0;
                        r_to_cnt   <= '0;
                        r_state    <= ST_WAIT_ACK;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_WAIT_ACK: begin
                    // Ack is checked before expiry so a same-cycle ack still succeeds
                    if (slave_ack) begin
                        if (r_read) begin
                            r_to_cnt <= '0;
                            r_rx_cnt <= '0;
                            r_state  <= ST_RECV;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_error <= 1'b1;
                        r_state <= ST_ERR;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_RECV: begin
                    // Each received bit restarts the inactivity window; data_out only moves on a full byte
                    if (rx_valid) begin
                        r_to_cnt   <= '0;
                        r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], rx_bit};
                        r_rx_cnt   <= r_rx_cnt + 1'b1;
                        if (r_rx_cnt == RX_LAST) begin
                            r_data_out <= {r_rx_shift[DATA_WIDTH-2:0], rx_bit};
                            r_done     <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_error <= 1'b1;
                        r_state <= ST_ERR;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_busy    <= 1'b0;
                    r_bus_req <= 1'b0;
                    r_bit_cnt <= '0;
                    r_to_cnt  <= '0;
                    r_rx_cnt  <= '0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign bus_req  = r_bus_req;
    assign tx_valid = r_tx_valid;
    // Gated so the line idles low outside SEND regardless of shifter contents
    assign tx_bit   = r_tx_valid & w_frame_msb;

endmodule

// File: tb/tb_master_port.sv
module tb_master_port;

    localparam int TO = 64;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        read_en;
    logic [13:0] addr_in;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        busy;
    logic        done;
    logic        error;
    logic        bus_req;
    logic        bus_grant;
    logic        tx_bit;
    logic        tx_valid;
    logic        slave_ack;
    logic        rx_bit;
    logic        rx_valid;

    typedef struct {
        logic [1:0] kind;   // {done, error}
        logic [7:0] data;
    } evt_t;

    localparam logic [1:0] EV_DONE = 2'b10;
    localparam logic [1:0] EV_ERR  = 2'b01;

    logic exp_tx[$];
    evt_t exp_evt[$];

    int n_checks = 0;
    int n_errors = 0;

    master_port #(
        .ADDR_WIDTH (14),
        .DATA_WIDTH (8),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .read_en   (read_en),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .bus_req   (bus_req),
        .bus_grant (bus_grant),
        .tx_bit    (tx_bit),
        .tx_valid  (tx_valid),
        .slave_ack (slave_ack),
        .rx_bit    (rx_bit),
        .rx_valid  (rx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [22:0] bits, input int len);
        for (int i = 0; i < len; i++) exp_tx.push_back(bits[len-1-i]);
    endtask

    task automatic push_evt(input logic [1:0] kind, input logic [7:0] data);
        evt_t e;
        e.kind = kind;
        e.data = data;
        exp_evt.push_back(e);
    endtask

    task automatic issue(input logic rd, input logic [13:0] a, input logic [7:0] d);
        enable  = 1'b1;
        read_en = rd;
        addr_in = a;
        data_in = d;
        tick();
        enable  = 1'b0;
        read_en = 1'b0;
    endtask

    task automatic wait_tx_start();
        int n;
        n = 0;
        while (!tx_valid && n < 50) begin
            tick();
            n++;
        end
        chk("tx_start_seen", tx_valid, 1);
    endtask

    task automatic wait_tx_end(output int len);
        len = 0;
        while (tx_valid && len < 40) begin
            len++;
            tick();
        end
    endtask

    // Monitor: compares every serial bit and every done/error pulse against the queues
    always @(negedge clk) begin
        if (reset) begin
            if (tx_valid) begin
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL tx_extra: got bit %0b expected no bit", tx_bit);
                end else begin
                    chk("tx_bit", tx_bit, exp_tx.pop_front());
                end
            end
            if (done || error) begin
                if (exp_evt.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL evt_extra: got done=%0b error=%0b expected none", done, error);
                end else begin
                    evt_t e;
                    e = exp_evt.pop_front();
                    chk("evt_kind", {done, error}, e.kind);
                    chk("evt_data", data_out, e.data);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int n;
        logic [7:0] rxv;

        reset = 1'b0; enable = 1'b0; read_en = 1'b0; addr_in = '0; data_in = '0;
        bus_grant = 1'b0; slave_ack = 1'b0; rx_bit = 1'b0; rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, error, bus_req, tx_valid, tx_bit, data_out}, 0);
        reset = 1'b1;
        tick();

        // Write 1001 <- 101, ack two cycles after the frame
        push_frame(23'b0_00001111101001_01100101, 23);
        push_evt(EV_DONE, 8'd0);
        issue(1'b0, 14'd1001, 8'd101);
        chk("wr_req_after_enable", {busy, bus_req}, 2'b11);
        bus_grant = 1'b1;
        wait_tx_start();
        wait_tx_end(len);
        chk("wr_frame_len", len, 23);
        tick();
        tick();
        slave_ack = 1'b1;
        tick();
        slave_ack = 1'b0;
        chk("wr_done_pulse", {done, bus_req}, 2'b11);
        tick();
        chk("wr_release", {busy, bus_req, done}, 0);
        bus_grant = 1'b0;
        tick();

        // Read 5097 -> 101, one idle cycle between rx bits
        push_frame(23'(15'b1_01001111101001), 15);
        push_evt(EV_DONE, 8'd101);
        issue(1'b1, 14'd5097, 8'd0);
        bus_grant = 1'b1;
        wait_tx_start();
        wait_tx_end(len);
        chk("rd_frame_len", len, 15);
        slave_ack = 1'b1;
        tick();
        slave_ack = 1'b0;
        rxv = 8'd101;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                rx_valid = 1'b0;
                tick();
            end
            rx_valid = 1'b1;
            rx_bit   = rxv[7-i];
            tick();
        end
        rx_valid = 1'b0;
        chk("rd_data_on_done", {done, data_out}, {1'b1, 8'd101});
        tick();
        chk("rd_release", {busy, bus_req}, 0);
        bus_grant = 1'b0;
        tick();

        // Write 9193, slave never acks
        push_frame(23'b0_10001111101001_00111100, 23);
        push_evt(EV_ERR, 8'd101);
        issue(1'b0, 14'd9193, 8'h3C);
        bus_grant = 1'b1;
        wait_tx_start();
        wait_tx_end(len);
        n = 0;
        while (!error && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_latency", n, TO);
        chk("timeout_data_held", data_out, 8'd101);
        tick();
        chk("timeout_release", {busy, bus_req, done}, 0);
        bus_grant = 1'b0;
        tick();

        // Grant lost during bit 7 of a write frame
        push_frame(23'b0000011, 7);
        push_evt(EV_ERR, 8'd101);
        issue(1'b0, 14'd1001, 8'd101);
        bus_grant = 1'b1;
        wait_tx_start();
        repeat (6) tick();
        bus_grant = 1'b0;
        tick();
        chk("gl_abort", {tx_valid, error, bus_req}, 3'b011);
        tick();
        chk("gl_release", {busy, bus_req, error}, 0);
        tick();

        // Second enable during SEND must be ignored
        push_frame(23'b0_00001111101001_01100101, 23);
        push_evt(EV_DONE, 8'd101);
        issue(1'b0, 14'd1001, 8'd101);
        bus_grant = 1'b1;
        wait_tx_start();
        repeat (3) tick();
        enable  = 1'b1;
        read_en = 1'b1;
        addr_in = 14'd5098;
        tick();
        enable  = 1'b0;
        read_en = 1'b0;
        chk("guard_busy", busy, 1);
        wait_tx_end(len);
        chk("guard_frame_rest", len, 19);
        slave_ack = 1'b1;
        tick();
        slave_ack = 1'b0;
        chk("guard_done", done, 1);
        tick();
        bus_grant = 1'b0;
        repeat (5) tick();
        chk("guard_no_requeue", {busy, bus_req}, 0);

        // Asynchronous reset in the middle of RECV, then a clean read
        push_frame(23'(15'b1_01001111101001), 15);
        issue(1'b1, 14'd5097, 8'd0);
        bus_grant = 1'b1;
        wait_tx_start();
        wait_tx_end(len);
        slave_ack = 1'b1;
        tick();
        slave_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_bit   = rxv[7-i];
            tick();
        end
        rx_valid  = 1'b0;
        bus_grant = 1'b0;
        reset     = 1'b0;
        #1;
        chk("reset_async", {busy, done, error, bus_req, tx_valid, tx_bit, data_out}, 0);
        tick();
        reset = 1'b1;
        tick();

        push_frame(23'(15'b1_01001111101001), 15);
        push_evt(EV_DONE, 8'd101);
        issue(1'b1, 14'd5097, 8'd0);
        bus_grant = 1'b1;
        wait_tx_start();
        wait_tx_end(len);
        slave_ack = 1'b1;
        tick();
        slave_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1;
            rx_bit   = rxv[7-i];
            tick();
        end
        rx_valid = 1'b0;
        chk("post_reset_read", {done, data_out}, {1'b1, 8'd101});
        tick();
        bus_grant = 1'b0;
        repeat (3) tick();

        chk("tx_queue_drained", exp_tx.size(), 0);
        chk("evt_queue_drained", exp_evt.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
